// File: rtl/uart_frame_pkg.sv
// Shared state encodings and constants for the UART response framer.
// Optional macro UART_FRAME_CHECKSUM_EN enables the trailing checksum byte.
package uart_frame_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_LOAD,
    ST_PAYLOAD,
`ifdef UART_FRAME_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_WAIT_HI,
    HS_WAIT_LO
  } hs_phase_t;

  // Byte that brings the running 8-bit sum to zero.
  function automatic logic [7:0] csum_of(input logic [7:0] sum);
    return 8'h00 - sum;
  endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// Three-phase start/busy handshake towards uart_tx: one byte per byte_go.
// byte_done is combinational so the next byte can issue on the following cycle.
module uart_tx_handshake
  import uart_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_go,
  input  logic [7:0] byte_in,
  output logic       byte_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  hs_phase_t  phase_reg;
  logic       tx_start_reg;
  logic [7:0] tx_data_reg;

  assign byte_done = (phase_reg == HS_WAIT_LO) && !tx_busy;
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg    <= HS_IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      tx_start_reg <= 1'b0;
      case (phase_reg)
        HS_ISSUE:   phase_reg <= HS_WAIT_HI;
        HS_WAIT_HI: if (tx_busy) phase_reg <= HS_WAIT_LO;
        HS_WAIT_LO: if (!tx_busy) phase_reg <= HS_IDLE;
        default:    phase_reg <= HS_IDLE;
      endcase
      // A new byte may start from idle or in the very cycle the previous one completes.
      if (byte_go) begin
        phase_reg    <= HS_ISSUE;
        tx_start_reg <= 1'b1;
        tx_data_reg  <= byte_in;
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frames result words as SYNC, LEN, little-endian payload bytes and an optional
// checksum (macro UART_FRAME_CHECKSUM_EN) towards a byte-level uart_tx.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [7:0]              frame_len,
  output logic                    frame_ready,
  input  logic [8*WORD_BYTES-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    frame_done
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam frame_state_t TAIL_STATE = ST_CSUM;
`else
  localparam frame_state_t TAIL_STATE = ST_DONE;
`endif

  frame_state_t            state_reg;
  logic [7:0]              len_reg;
  logic [7:0]              words_left_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [IDX_W-1:0]        idx_next;
  logic [8*WORD_BYTES-1:0] word_reg;
  logic [7:0]              word_lanes [WORD_BYTES];
  logic                    byte_go;
  logic [7:0]              byte_in;
  logic                    byte_done;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]              sum_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word_lanes[gi] = word_reg[8*gi +: 8];
    end
  endgenerate

  assign idx_next    = idx_reg + IDX_W'(1);
  assign frame_ready = (state_reg == ST_IDLE);
  assign s_ready     = (state_reg == ST_LOAD);
  assign frame_done  = (state_reg == ST_DONE);

  // Decides the byte to issue in the same cycle the previous byte completes,
  // which keeps the gap between bytes to a single cycle.
  always_comb begin
    byte_go = 1'b0;
    byte_in = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          byte_go = 1'b1;
          byte_in = SYNC_BYTE;
        end
      end
      ST_SYNC: begin
        if (byte_done) begin
          byte_go = 1'b1;
          byte_in = len_reg;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_LEN: begin
        if (byte_done && (len_reg == 8'd0)) begin
          byte_go = 1'b1;
          byte_in = csum_of(sum_reg);
        end
      end
`endif
      ST_LOAD: begin
        if (s_valid) begin
          byte_go = 1'b1;
          byte_in = s_data[7:0];
        end
      end
      ST_PAYLOAD: begin
        if (byte_done) begin
          if (idx_reg != LAST_IDX) begin
            byte_go = 1'b1;
            byte_in = word_lanes[idx_next];
          end
`ifdef UART_FRAME_CHECKSUM_EN
          else if (words_left_reg == 8'd1) begin
            byte_go = 1'b1;
            byte_in = csum_of(sum_reg);
          end
`endif
        end
      end
      default: ;
    endcase
  end

  uart_tx_handshake u_handshake (
    .clk       (clk),
    .rst       (rst),
    .byte_go   (byte_go),
    .byte_in   (byte_in),
    .byte_done (byte_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      len_reg        <= 8'h00;
      words_left_reg <= 8'h00;
      idx_reg        <= '0;
      word_reg       <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_reg        <= 8'h00;
`endif
    end else begin
`ifdef UART_FRAME_CHECKSUM_EN
      // SYNC is wiped by the clear below; folding in the checksum byte is harmless.
      if (byte_go) sum_reg <= sum_reg + byte_in;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (frame_start) begin
            len_reg        <= frame_len;
            words_left_reg <= frame_len;
            state_reg      <= ST_SYNC;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_reg        <= 8'h00;
`endif
          end
        end
        ST_SYNC: if (byte_done) state_reg <= ST_LEN;
        ST_LEN: begin
          if (byte_done) state_reg <= (len_reg != 8'd0) ? ST_LOAD : TAIL_STATE;
        end
        ST_LOAD: begin
          if (s_valid) begin
            word_reg  <= s_data;
            idx_reg   <= '0;
            state_reg <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (byte_done) begin
            if (idx_reg == LAST_IDX) begin
              words_left_reg <= words_left_reg - 8'd1;
              state_reg      <= (words_left_reg != 8'd1) ? ST_LOAD : TAIL_STATE;
            end else begin
              idx_reg <= idx_next;
            end
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CSUM: if (byte_done) state_reg <= ST_DONE;
`endif
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx with a behavioural uart_tx (CLK_PER_BIT=4).
`timescale 1ns/1ps
module tb_uart_frame_tx;

  localparam int CPB = 4;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CSUM_N = 1;
`else
  localparam int CSUM_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  frame_len = 8'h00;
  logic        frame_ready;
  logic [31:0] s_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        frame_done;

  uart_frame_tx #(.WORD_BYTES(4), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .frame_ready (frame_ready),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural uart_tx: busy for ten bit times after an accepted start.
  int         bit_cnt = 0;
  logic [7:0] held = 8'h00;
  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      bit_cnt <= 0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        bit_cnt <= 10*CPB - 1;
        held    <= tx_data;
      end
    end else if (bit_cnt == 0) begin
      tx_busy <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt - 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          n_start = 0;
  int          n_done = 0;
  int          n_xfer = 0;
  bit          s_ready_seen = 1'b0;
  bit          start_d1 = 1'b0, busy_d1 = 1'b0, busy_d2 = 1'b0;
  bit          done_pending = 1'b0, data_moved = 1'b0;
  logic [7:0]  mon_exp;
  logic [7:0]  exp_q[$];
  logic [31:0] wq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every tx_start and watches handshake rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        n_start++;
        check("start_while_busy", {31'b0, tx_busy}, 32'd0);
        check("start_back_to_back", {31'b0, start_d1}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("byte", {24'b0, tx_data}, {24'b0, mon_exp});
          $display("byte %0d data %02h expect %02h", n_start, tx_data, mon_exp);
        end
      end
      if (done_pending) begin
        check("ready_after_done", {31'b0, frame_ready}, 32'd1);
        done_pending = 1'b0;
      end
      if (frame_done) begin
        n_done++;
        check("done_timing", {30'b0, busy_d2, busy_d1}, 32'd2);
        done_pending = 1'b1;
        $display("frame_done %0d", n_done);
      end
      if (s_valid && s_ready) n_xfer++;
      if (s_ready) s_ready_seen = 1'b1;
      if (busy_d1 && !tx_busy) begin
        check("data_stable", {31'b0, data_moved}, 32'd0);
        data_moved = 1'b0;
      end
      if (tx_busy && (tx_data !== held)) data_moved = 1'b1;
    end else begin
      data_moved   = 1'b0;
      done_pending = 1'b0;
    end
    start_d1 = tx_start;
    busy_d2  = busy_d1;
    busy_d1  = tx_busy;
  end

  task automatic push_frame(input logic [7:0] len);
    logic [7:0] sum;
    logic [7:0] b;
    sum = len;
    exp_q.push_back(8'hA5);
    exp_q.push_back(len);
    foreach (wq[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = wq[i][8*k +: 8];
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
    if (CSUM_N == 1) exp_q.push_back(8'h00 - sum);
  endtask

  task automatic start_frame(input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (frame_ready) ok = 1'b1;
    end
    check("ready_before_start", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_len   = len;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("accept_latency", {31'b0, tx_start}, 32'd1);
  endtask

  task automatic feed_word(input logic [31:0] w, input int stall);
    bit ok;
    int snap;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got s_ready 0 expected 1");
      return;
    end
    snap = n_start;
    repeat (stall) @(negedge clk);
    if (stall > 0) check("stall_no_start", n_start - snap, 32'd0);
    @(posedge clk); #1;
    s_data  = w;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("xfer_latency", {23'b0, tx_start, tx_data}, {23'b0, 1'b1, w[7:0]});
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20000 && !ok; n++) begin
      @(negedge clk);
      if (n_done >= target) ok = 1'b1;
    end
    check("frame_done_seen", n_done, target);
    repeat (80) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("no_extra_frame", n_done, target);
  endtask

  int snap_x, snap_s, snap_d;

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_frame_ready", {31'b0, frame_ready}, 32'd1);
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // One word, hand-computed bytes.
    exp_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CSUM_N == 1) exp_q.push_back(8'hF5);
    snap_x = n_xfer;
    start_frame(8'd1);
    feed_word(32'h04030201, 0);
    wait_done(1);
    check("one_word_xfers", n_xfer - snap_x, 32'd1);

    // Zero length: no payload, s_ready never raised.
    exp_q = '{8'hA5, 8'h00};
    if (CSUM_N == 1) exp_q.push_back(8'h00);
    s_ready_seen = 1'b0;
    snap_x = n_xfer;
    start_frame(8'd0);
    wait_done(2);
    check("zero_len_s_ready", {31'b0, s_ready_seen}, 32'd0);
    check("zero_len_xfers", n_xfer - snap_x, 32'd0);

    // Stall 50 cycles before the second word.
    wq = '{32'hDEADBEEF, 32'h8899AABB};
    push_frame(8'd2);
    start_frame(8'd2);
    feed_word(wq[0], 0);
    feed_word(wq[1], 50);
    wait_done(3);

    // frame_start mid-frame must be ignored.
    wq = '{32'h11223344, 32'hCAFEF00D, 32'h00FF7F80};
    push_frame(8'd3);
    start_frame(8'd3);
    feed_word(wq[0], 0);
    @(posedge clk); #1;
    frame_start = 1'b1;
    frame_len   = 8'd7;
    repeat (3) @(posedge clk);
    #1;
    frame_start = 1'b0;
    frame_len   = 8'd3;
    feed_word(wq[1], 0);
    feed_word(wq[2], 0);
    wait_done(4);

    // Reset during payload byte 2.
    wq = '{32'h55667788, 32'h99AABBCC};
    push_frame(8'd2);
    snap_s = n_start;
    start_frame(8'd2);
    feed_word(wq[0], 0);
    for (int n = 0; n < 3000 && (n_start - snap_s) < 5; n++) @(negedge clk);
    check("reached_payload_byte2", n_start - snap_s, 32'd5);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_frame_ready", {31'b0, frame_ready}, 32'd1);
    check("mid_rst_tx_start", {31'b0, tx_start}, 32'd0);
    snap_s = n_start;
    snap_d = n_done;
    repeat (60) @(negedge clk);
    check("mid_rst_quiet_start", n_start - snap_s, 32'd0);
    check("mid_rst_no_done", n_done - snap_d, 32'd0);
    wq = '{32'h0BADC0DE};
    push_frame(8'd1);
    start_frame(8'd1);
    feed_word(wq[0], 0);
    wait_done(5);

    // Maximum length with random words.
    wq.delete();
    for (int i = 0; i < 255; i++) wq.push_back($urandom);
    push_frame(8'd255);
    snap_s = n_start;
    start_frame(8'd255);
    foreach (wq[i]) feed_word(wq[i], 0);
    wait_done(6);
    check("max_byte_count", n_start - snap_s, 2 + 1020 + CSUM_N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
